// File: rtl/array_serializer_pkg.sv
// Shared types and helpers for the array serializer block.
package array_serializer_pkg;

    // Serializer control states.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Index width for a given element count; at least one bit so SIZE=1 still has a port.
    function automatic int calc_idx_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/array_snapshot_reg.sv
// Single-enable shadow register holding a full SIZE x BIT_WIDTH array.
module array_snapshot_reg #(
    parameter int SIZE      = 4,
    parameter int BIT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [SIZE-1:0][BIT_WIDTH-1:0] d,
    output logic [SIZE-1:0][BIT_WIDTH-1:0] q
);

    logic [SIZE-1:0][BIT_WIDTH-1:0] shadow_r;

    // Capture the whole array in one cycle when enabled; clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_r <= '0;
        end else if (enable) begin
            shadow_r <= d;
        end
    end

    assign q = shadow_r;

endmodule

// File: rtl/array_serializer.sv
// Snapshots a parallel array on start and streams it out element by element
// over a valid/ready interface, index 0 first.
module array_serializer
    import array_serializer_pkg::*;
#(
    parameter  int SIZE      = 4,
    parameter  int BIT_WIDTH = 8,
    localparam int IDX_W     = calc_idx_w(SIZE)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [SIZE-1:0][BIT_WIDTH-1:0] array_in,
    output logic                           busy,
    output logic [BIT_WIDTH-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IDX_W-1:0]               out_index,
    output logic                           out_last,
    output logic                           done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    state_t                         state_r;
    state_t                         state_s;
    logic [IDX_W-1:0]               index_r;
    logic [IDX_W-1:0]               index_s;
    logic                           valid_r;
    logic                           valid_s;
    logic                           busy_r;
    logic                           done_r;
    logic                           done_s;
    logic                           capture_s;
    logic [SIZE-1:0][BIT_WIDTH-1:0] shadow_r;
    logic [BIT_WIDTH-1:0]           data_s;
    logic                           last_s;

    array_snapshot_reg #(
        .SIZE      (SIZE),
        .BIT_WIDTH (BIT_WIDTH)
    ) u_snapshot (
        .clk    (clk),
        .reset  (reset),
        .enable (capture_s),
        .d      (array_in),
        .q      (shadow_r)
    );

    // Next-state logic: capture on start in IDLE, advance on each handshake, finish after the last element.
    always_comb begin
        state_s   = state_r;
        index_s   = index_r;
        done_s    = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    capture_s = 1'b1;
                    index_s   = IDX_ZERO;
                    state_s   = SEND;
                end else begin
                    state_s   = IDLE;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (index_r == LAST_IDX) begin
                        state_s = IDLE;
                        index_s = IDX_ZERO;
                        done_s  = 1'b1;
                    end else begin
                        index_s = index_r + IDX_ONE;
                    end
                end else begin
                    index_s = index_r;
                end
            end
            default: begin
                state_s = IDLE;
                index_s = IDX_ZERO;
            end
        endcase
        valid_s = (state_s == SEND);
    end

    // Control registers; valid and busy track the SEND state one cycle ahead so both come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            index_r <= IDX_ZERO;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            index_r <= index_s;
            valid_r <= valid_s;
            busy_r  <= valid_s;
            done_r  <= done_s;
        end
    end

    // Element mux from the shadow copy; last flag is qualified by SEND so it stays low while idle.
    always_comb begin
        data_s = shadow_r[0];
        for (int i = 0; i < SIZE; i++) begin
            data_s = (index_r == IDX_W'(i)) ? shadow_r[i] : data_s;
        end
        last_s = (state_r == SEND) && (index_r == LAST_IDX);
    end

    assign out_data  = data_s;
    assign out_index = index_r;
    assign out_last  = last_s;
    assign out_valid = valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
